// File: rtl/ac_coef_scheduler.sv
// AC coefficient scheduler: walks one slice frequency-major/block-minor, emits one
// run/level/sign codeword per nonzero AC coefficient, then a single flush request.
module ac_coef_scheduler #(
  parameter int COEF_W     = 16,
  parameter int MAX_BLOCKS = 8,
  parameter int ADDR_W     = 9,
  parameter int RUN_W      = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        blocks_per_slice,
  output logic              busy,
  output logic              done,
  output logic              coef_rd_en,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic [RUN_W-1:0]  cw_run,
  output logic [COEF_W-1:0] cw_level,
  output logic              cw_sign,
  output logic              flush_valid,
  input  logic              flush_ready
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | coefficient read strobe for (blk, scan_idx)
  // CHECK | read data present; zero extends the run, nonzero latches a codeword
  // EMIT  | codeword held on cw_* until cw_ready
  // FLUSH | end-of-slice request held until flush_ready
  // DONE  | one-cycle completion pulse

  localparam int BLK_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam int N_W   = $clog2(MAX_BLOCKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_EMIT, S_FLUSH, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [N_W-1:0]   n_blk;
  logic [N_W-1:0]   n_req;
  logic [BLK_W-1:0] blk;
  logic [5:0]       scan_idx;
  logic [RUN_W-1:0] run;
  logic             blk_wrap;
  logic             last_pos;
  logic             coef_zero;
  logic             advance;

  assign n_req     = (blocks_per_slice > 8'(MAX_BLOCKS)) ? N_W'(MAX_BLOCKS)
                                                         : N_W'(blocks_per_slice);
  assign blk_wrap  = (N_W'(blk) == n_blk - N_W'(1));
  assign last_pos  = blk_wrap && (scan_idx == 6'd63);
  assign coef_zero = (coef_data == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    advance     = 1'b0;
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    coef_rd_en  = (state == S_READ);
    cw_valid    = (state == S_EMIT);
    flush_valid = (state == S_FLUSH);
    coef_addr   = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (n_req == '0) ? S_FLUSH : S_READ;
      end
      S_READ: begin
        coef_addr = ADDR_W'({blk, scan_idx});
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (coef_zero) begin
          advance   = 1'b1;
          state_nxt = last_pos ? S_FLUSH : S_READ;
        end else begin
          state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (cw_ready) begin
          advance   = 1'b1;
          state_nxt = last_pos ? S_FLUSH : S_READ;
        end
      end
      S_FLUSH: begin
        if (flush_ready) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_blk    <= '0;
      blk      <= '0;
      scan_idx <= '0;
      run      <= '0;
      cw_run   <= '0;
      cw_level <= '0;
      cw_sign  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        n_blk    <= n_req;
        blk      <= '0;
        scan_idx <= 6'd1;
        run      <= '0;
      end
      // Two's complement negate keeps the most negative value exact as unsigned.
      if (state == S_CHECK && !coef_zero) begin
        cw_run   <= run;
        cw_sign  <= coef_data[COEF_W-1];
        cw_level <= coef_data[COEF_W-1] ? (~coef_data + COEF_W'(1)) : coef_data;
      end
      if (advance) begin
        if (blk_wrap) begin
          blk      <= '0;
          scan_idx <= scan_idx + 6'd1;
        end else begin
          blk <= blk + BLK_W'(1);
        end
        run <= (state == S_CHECK) ? run + RUN_W'(1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_ac_coef_scheduler.sv
// Bench for ac_coef_scheduler: directed slice table, hand-written backpressure and
// reset sequences, and randomized slices checked against a scan-order reference model.
`timescale 1ns/1ps
module tb_ac_coef_scheduler;
  localparam int COEF_W = 16, MAX_BLOCKS = 8, ADDR_W = 9, RUN_W = 10, BUDGET = 6000;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        blocks_per_slice = 8'd0;
  logic              busy, done, coef_rd_en, cw_valid, cw_sign, flush_valid;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [RUN_W-1:0]  cw_run;
  logic [COEF_W-1:0] cw_level;
  logic              cw_ready = 1'b0;
  logic              flush_ready = 1'b0;

  logic [COEF_W-1:0] mem [0:511];
  int checks = 0;
  int errors = 0;
  int nflush;

  typedef struct packed {
    logic [RUN_W-1:0]  run;
    logic [COEF_W-1:0] lvl;
    logic              sgn;
  } cw_t;
  cw_t got_q[$];
  cw_t exp_q[$];

  typedef struct {
    int  bps;
    int  a0, v0, a1, v1;
    int  reads, ncw, cycles;
    cw_t c0, c1;
  } vec_t;
  vec_t tbl[7];

  ac_coef_scheduler #(.COEF_W(COEF_W), .MAX_BLOCKS(MAX_BLOCKS), .ADDR_W(ADDR_W), .RUN_W(RUN_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .blocks_per_slice(blocks_per_slice),
    .busy(busy), .done(done), .coef_rd_en(coef_rd_en), .coef_addr(coef_addr),
    .coef_data(coef_data), .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_run(cw_run),
    .cw_level(cw_level), .cw_sign(cw_sign), .flush_valid(flush_valid), .flush_ready(flush_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (coef_rd_en) coef_data <= mem[coef_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic cw_t mk(input int run, input int lvl, input int sgn);
    cw_t c;
    c.run = RUN_W'(run);
    c.lvl = COEF_W'(lvl);
    c.sgn = sgn[0];
    return c;
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 512; a++) mem[a] = '0;
  endtask

  // Reference: scan positions in AC order and count zeros between nonzeros.
  task automatic model(input int bps);
    int n, run, iv;
    n = (bps > MAX_BLOCKS) ? MAX_BLOCKS : bps;
    exp_q.delete();
    run = 0;
    for (int s = 1; s < 64; s++) begin
      for (int b = 0; b < n; b++) begin
        iv = int'($signed(mem[b*64 + s]));
        if (iv == 0) run++;
        else begin
          exp_q.push_back(mk(run, (iv < 0) ? -iv : iv, (iv < 0) ? 1 : 0));
          run = 0;
        end
      end
    end
  endtask

  task automatic run_slice(input int bps, input bit rand_rdy, input bit poke,
                           output int cycles, output int reads);
    int  k, viol;
    bit  seen_done, pend_cw, pend_fl;
    cw_t hold, cur;
    got_q.delete();
    nflush = 0; reads = 0; cycles = -1; k = 0; viol = 0;
    seen_done = 0; pend_cw = 0; pend_fl = 0; hold = '0;
    @(negedge clock);
    if (!rand_rdy) begin cw_ready = 1'b1; flush_ready = 1'b1; end
    start = 1'b1;
    blocks_per_slice = 8'(bps);
    while (!seen_done && k < BUDGET) begin
      @(negedge clock);
      k++;
      start = 1'b0;
      cur = {cw_run, cw_level, cw_sign};
      if (coef_rd_en) reads++;
      if (!busy) viol++;
      if (cw_valid && flush_valid) viol++;
      if (pend_cw && (!cw_valid || cur != hold)) viol++;
      if (pend_fl && !flush_valid) viol++;
      if ((pend_cw || pend_fl) && coef_rd_en) viol++;
      if (done) begin
        seen_done = 1;
        cycles = k;
        if (nflush != 1) viol++;
      end
      if (rand_rdy) begin
        cw_ready    = ($urandom_range(0, 3) != 0);
        flush_ready = ($urandom_range(0, 3) != 0);
      end
      if (cw_valid && cw_ready) got_q.push_back(cur);
      if (flush_valid && flush_ready) nflush++;
      pend_cw = cw_valid && !cw_ready;
      pend_fl = flush_valid && !flush_ready;
      hold = cur;
      if (poke && (done || $urandom_range(0, 7) == 0)) begin
        start = 1'b1;
        blocks_per_slice = 8'd2;
      end
    end
    chk("slice_done_seen", seen_done, 1);
    @(negedge clock);
    start = 1'b0;
    chk("idle_after_done", {busy, done}, 0);
    chk("slice_invariants", viol, 0);
    chk("flush_count", nflush, 1);
  endtask

  task automatic bp_test();
    int  k, viol;
    cw_t hold, cur;
    clear_mem();
    mem[1] = 16'd5;
    cw_ready = 1'b0; flush_ready = 1'b0; viol = 0; k = 0;
    @(negedge clock);
    start = 1'b1; blocks_per_slice = 8'd1;
    do begin @(negedge clock); start = 1'b0; k++; end while (!cw_valid && k < 50);
    chk("bp_cw_reached", cw_valid, 1);
    hold = {cw_run, cw_level, cw_sign};
    chk("bp_cw_value", hold, mk(0, 5, 0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      cur = {cw_run, cw_level, cw_sign};
      if (!cw_valid || cur != hold || coef_rd_en || flush_valid) viol++;
    end
    chk("bp_cw_hold", viol, 0);
    cw_ready = 1'b1;
    @(negedge clock);
    chk("bp_resume_read", {cw_valid, coef_rd_en}, 1);
    k = 0;
    while (!flush_valid && k < 300) begin @(negedge clock); k++; end
    chk("bp_flush_reached", flush_valid, 1);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!flush_valid || done || cw_valid || coef_rd_en) viol++;
    end
    chk("bp_flush_hold", viol, 0);
    flush_ready = 1'b1;
    @(negedge clock);
    chk("bp_done", {done, flush_valid}, 2);
    @(negedge clock);
    chk("bp_idle", busy, 0);
  endtask

  initial begin
    int cyc, rd, bps, nn, k;
    tbl[0] = '{bps:4,   a0:-1,  v0:0,      a1:-1, v1:0,   reads:252, ncw:0, cycles:506,  c0:'0, c1:'0};
    tbl[1] = '{bps:1,   a0:1,   v0:5,      a1:3,  v1:-2,  reads:63,  ncw:2, cycles:130,  c0:'0, c1:'0};
    tbl[2] = '{bps:2,   a0:65,  v0:-32768, a1:-1, v1:0,   reads:126, ncw:1, cycles:255,  c0:'0, c1:'0};
    tbl[3] = '{bps:8,   a0:511, v0:-1,     a1:-1, v1:0,   reads:504, ncw:1, cycles:1011, c0:'0, c1:'0};
    tbl[4] = '{bps:0,   a0:-1,  v0:0,      a1:-1, v1:0,   reads:0,   ncw:0, cycles:2,    c0:'0, c1:'0};
    tbl[5] = '{bps:200, a0:1,   v0:7,      a1:-1, v1:0,   reads:504, ncw:1, cycles:1011, c0:'0, c1:'0};
    tbl[6] = '{bps:3,   a0:129, v0:100,    a1:2,  v1:-100, reads:189, ncw:2, cycles:382, c0:'0, c1:'0};
    tbl[1].c0 = mk(0, 5, 0);   tbl[1].c1 = mk(1, 2, 1);
    tbl[2].c0 = mk(1, 32768, 1);
    tbl[3].c0 = mk(503, 1, 1);
    tbl[5].c0 = mk(0, 7, 0);
    tbl[6].c0 = mk(2, 100, 0); tbl[6].c1 = mk(0, 100, 1);

    clear_mem();
    repeat (2) @(negedge clock);
    chk("reset_outputs", {busy, done, coef_rd_en, coef_addr, cw_valid, cw_run, cw_level,
                          cw_sign, flush_valid}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (tbl[i]) begin
      clear_mem();
      if (tbl[i].a0 >= 0) mem[tbl[i].a0] = COEF_W'(tbl[i].v0);
      if (tbl[i].a1 >= 0) mem[tbl[i].a1] = COEF_W'(tbl[i].v1);
      run_slice(tbl[i].bps, 0, (i == 3), cyc, rd);
      chk($sformatf("t%0d_reads", i), rd, tbl[i].reads);
      chk($sformatf("t%0d_ncw", i), got_q.size(), tbl[i].ncw);
      chk($sformatf("t%0d_cycles", i), cyc, tbl[i].cycles);
      if (tbl[i].ncw > 0 && got_q.size() > 0) chk($sformatf("t%0d_cw0", i), got_q[0], tbl[i].c0);
      if (tbl[i].ncw > 1 && got_q.size() > 1) chk($sformatf("t%0d_cw1", i), got_q[1], tbl[i].c1);
    end

    bp_test();

    clear_mem();
    mem[1] = 16'd5;
    cw_ready = 1'b0;
    @(negedge clock);
    start = 1'b1; blocks_per_slice = 8'd1;
    k = 0;
    do begin @(negedge clock); start = 1'b0; k++; end while (!cw_valid && k < 50);
    chk("rst_emit_reached", cw_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_emit", {busy, done, coef_rd_en, coef_addr, cw_valid, cw_run, cw_level,
                         cw_sign, flush_valid}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_slice(1, 0, 0, cyc, rd);
    chk("post_rst_reads", rd, 63);
    chk("post_rst_ncw", got_q.size(), 1);
    if (got_q.size() > 0) chk("post_rst_cw", got_q[0], mk(0, 5, 0));

    for (int it = 0; it < 8; it++) begin
      bps = $urandom_range(0, 10);
      nn = (bps > MAX_BLOCKS) ? MAX_BLOCKS : bps;
      for (int a = 0; a < 512; a++) mem[a] = ($urandom_range(0, 15) == 0) ? COEF_W'($urandom) : '0;
      if (it == 2) mem[64 + 5] = 16'h8000;
      model(bps);
      run_slice(bps, 1, 1, cyc, rd);
      chk($sformatf("rnd%0d_reads", it), rd, 63 * nn);
      chk($sformatf("rnd%0d_ncw", it), got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
        chk($sformatf("rnd%0d_cw%0d", it, j), got_q[j], exp_q[j]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
